// File: rtl/ctr_cipher_byte_serializer.sv
// Ciphertext block FIFO plus byte serializer: buffers 256-bit blocks, emits an AXI-stream byte stream.
// Optional CTR_SERIALIZER_DROP_CNT_EN builds a saturating 16-bit dropped-block counter.
module ctr_cipher_byte_serializer #(
  parameter int DATA_WIDTH = 256,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [OUT_WIDTH-1:0]          m_tdata,
  output logic                          m_tlast,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, EMIT} state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  ovf_q, ovf_d;
  logic                  hs, fifo_empty, pop, push_ok, drop;

  always_comb begin
    hs         = (state_q == EMIT) & m_tready;
    fifo_empty = (count_q == '0);
    // The shift register reloads from the FIFO either from idle or on the final byte of a block.
    pop        = !fifo_empty & ((state_q == IDLE) | (hs & last_q));
    push_ok    = in_valid & ((count_q != CW'(FIFO_DEPTH)) | pop);
    drop       = in_valid & !push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (pop) begin
      state_d = EMIT;
      shift_d = mem_q[rd_ptr_q];
      idx_d   = '0;
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        shift_d = '0;
        idx_d   = '0;
      end else begin
        shift_d = shift_q << OUT_WIDTH;
        idx_d   = idx_q + IW'(1);
      end
    end
    last_d = (state_d == EMIT) & (idx_d == IW'(BEATS - 1));
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef CTR_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign m_tvalid   = (state_q == EMIT);
  assign m_tdata    = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
  assign m_tlast    = last_q;
  assign overflow   = ovf_q;
  assign fifo_level = count_q;
endmodule
